lane_aligner_rx: RTL and testbench

Per-lane receive front end that turns a serial bit stream into aligned bytes. It shifts in one bit per `clk_32f` and hunts for the COM symbol (`8'hBC`). It locks byte boundaries after a run of consecutive aligned COMs, then emits each non-COM byte as a one-cycle strobed parallel word. It sits between the serial lane input (`data_in_0`/`data_in_1`) and the per-lane 8b→32b demux; one instance per lane.

---
 rtl/lane_aligner_rx_pkg.sv | 22 ++
 rtl/lane_aligner_rx.sv | 120 ++++++++++++
 tb/tb_lane_aligner_rx.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_aligner_rx_pkg.sv
// Shared constants and types for the per-lane receive aligner.
package lane_aligner_rx_pkg;

  // Alignment / idle symbol sent on an idle lane.
  localparam logic [7:0] COM_SYMBOL_DEFAULT = 8'hBC;

  // COM run length saturates here (4-bit debug counter).
  localparam logic [3:0] COM_COUNT_MAX = 4'd15;

  // Alignment FSM encodings.
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Saturating increment for the COM run counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] value);
    return (value == COM_COUNT_MAX) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/lane_aligner_rx.sv
// Serial-to-byte lane aligner: hunts for COM at any bit offset, confirms a
// run of boundary-aligned COMs, then strobes out every non-COM byte.
module lane_aligner_rx
  import lane_aligner_rx_pkg::*;
#(
  parameter logic [7:0]  COM_SYMBOL = COM_SYMBOL_DEFAULT,
  parameter int unsigned COM_LOCK   = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [3:0] com_count
);

  localparam logic [3:0] LOCK_CNT = 4'(COM_LOCK);

  state_t     state;
  state_t     state_next;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_next;
  logic [3:0] com_count_next;
  logic [7:0] data_next;
  logic       valid_next;
  logic       is_com;
  logic       boundary;

  assign is_com   = (sr == COM_SYMBOL);
  assign boundary = (bit_cnt == 3'd0);
  assign active   = (state == LOCKED);

  // Shift one serial bit in per edge, MSB of each byte first.
  always_ff @(posedge clk_32f or posedge reset) begin
    // NOTE: clocked state uses <= so every flop samples pre-edge values;
    // blocking = here would make the result depend on block ordering.
    if (reset) sr <= 8'h00;
    else       sr <= {sr[6:0], data_in};
  end

  // FSM state register.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_next;
  end

  // Boundary counter, COM run counter and the strobed output byte.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      com_count <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_next;
      com_count <= com_count_next;
      data_out  <= data_next;
      valid_out <= valid_next;
    end
  end

  // Next-state and datapath decisions; only boundary cycles look at sr
  // once aligned, so a COM pattern straddling two bytes is ignored.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    com_count_next = com_count;
    data_next      = data_out;
    valid_next     = 1'b0;

    case (state)
      HUNT: begin
        if (is_com) begin
          // The matching edge is bit 0 of the next byte's boundary window.
          bit_cnt_next   = 3'd1;
          com_count_next = 4'd1;
          state_next     = (LOCK_CNT == 4'd1) ? LOCKED : CONFIRM;
        end
      end

      CONFIRM: begin
        bit_cnt_next = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_count_next = com_count + 4'd1;
            if (com_count_next == LOCK_CNT) state_next = LOCKED;
          end else begin
            // Broken run: resume hunting on the following cycle.
            state_next     = HUNT;
            com_count_next = 4'd0;
            bit_cnt_next   = 3'd0;
          end
        end
      end

      LOCKED: begin
        bit_cnt_next = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_count_next = sat_inc(com_count);
          end else begin
            data_next      = sr;
            valid_next     = 1'b1;
            com_count_next = 4'd0;
          end
        end
      end

      default: begin
        state_next   = HUNT;
        bit_cnt_next = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_lane_aligner_rx.sv
// Self-checking bench for lane_aligner_rx: directed vector table, hand-built
// timing/reset sequences, and randomized streams against a bit-history model.
module tb_lane_aligner_rx;

  localparam logic [7:0] COM    = 8'hBC;
  localparam int         LOCK_N = 4;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic [3:0] com_count;

  lane_aligner_rx #(.COM_SYMBOL(COM), .COM_LOCK(LOCK_N)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active),
    .com_count(com_count)
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the raw bit history: a HUNT match at edge t schedules byte
  // checks at edges t+8, t+16, ...; each check looks at the last 8 bits.
  localparam int M_HUNT = 0, M_CONFIRM = 1, M_LOCKED = 2;

  bit         hist[$];
  int         n_edges;
  int         m_mode;
  int         m_next_chk;
  int         m_cnt;
  logic [7:0] m_data;
  bit         m_valid;

  function automatic logic [7:0] last_byte();
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = hist.size() - 8 + i;
      w[7-i] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return w;
  endfunction

  function automatic void model_reset();
    hist.delete();
    n_edges    = 0;
    m_mode     = M_HUNT;
    m_next_chk = 0;
    m_cnt      = 0;
    m_data     = 8'h00;
    m_valid    = 1'b0;
  endfunction

  function automatic void model_edge(input bit b);
    logic [7:0] w;
    w = last_byte();
    m_valid = 1'b0;
    if (m_mode == M_HUNT) begin
      if (w == COM) begin
        m_cnt      = 1;
        m_mode     = (LOCK_N == 1) ? M_LOCKED : M_CONFIRM;
        m_next_chk = n_edges + 8;
      end
    end else if (n_edges == m_next_chk) begin
      m_next_chk += 8;
      if (m_mode == M_CONFIRM) begin
        if (w == COM) begin
          m_cnt++;
          if (m_cnt == LOCK_N) m_mode = M_LOCKED;
        end else begin
          m_mode = M_HUNT;
          m_cnt  = 0;
        end
      end else begin
        if (w != COM) begin
          m_data  = w;
          m_valid = 1'b1;
          m_cnt   = 0;
        end else if (m_cnt < 15) begin
          m_cnt++;
        end
      end
    end
    hist.push_back(b);
    n_edges++;
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [7:0] strobe_q[$];
  int         strobe_t[$];
  int         first_active;

  task automatic send_bit(input bit b);
    logic [13:0] exp;
    data_in = b;
    @(posedge clk_32f);
    model_edge(b);
    @(negedge clk_32f);
    exp = {m_data, m_valid, (m_mode == M_LOCKED), 4'(m_cnt)};
    check($sformatf("cycle%0d {data,valid,active,cnt}", n_edges),
          {data_out, valid_out, active, com_count}, exp);
    if (valid_out) begin
      strobe_q.push_back(data_out);
      strobe_t.push_back(n_edges);
    end
    if (active && first_active == 0) first_active = n_edges;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  // Asserts reset mid-cycle (called at a falling edge), checks outputs clear
  // without any clock edge, holds for ncyc edges and releases.
  task automatic do_reset(input int ncyc);
    #2;
    reset = 1'b1;
    #1;
    check("reset_clear {data,valid,active,cnt}", {data_out, valid_out, active, com_count}, 14'h0);
    repeat (ncyc) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    model_reset();
    strobe_q.delete();
    strobe_t.delete();
    first_active = 0;
  endtask

  // ---------------- directed vector table ----------------
  // Byte k of the stream is bytes[127-8k -: 8]; strobe k is strobes[31-8k -: 8].
  typedef struct packed {
    logic [2:0]   pre;
    logic [1:0]   pre_len;
    logic [127:0] bytes;
    logic [4:0]   n_bytes;
    logic [31:0]  strobes;
    logic [2:0]   n_strobes;
    logic         exp_active;
    logic [3:0]   exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vec_t v;
    data_in = 1'b0;
    reset   = 1'b0;
    model_reset();
    first_active = 0;

    vecs[0] = '{pre: 3'b101, pre_len: 2'd3, bytes: {{4{8'hBC}}, 96'h0}, n_bytes: 5'd4,
                strobes: 32'h0, n_strobes: 3'd0, exp_active: 1'b1, exp_cnt: 4'd4};
    vecs[1] = '{pre: 3'b000, pre_len: 2'd0,
                bytes: {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'h3C, 8'hBC, 8'hFF, 64'h0}, n_bytes: 5'd8,
                strobes: {8'hA5, 8'h3C, 8'hFF, 8'h00}, n_strobes: 3'd3, exp_active: 1'b1, exp_cnt: 4'd0};
    vecs[2] = '{pre: 3'b000, pre_len: 2'd0,
                bytes: {8'hBC, 8'hBC, 8'h12, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h77, 64'h0}, n_bytes: 5'd8,
                strobes: {8'h77, 24'h0}, n_strobes: 3'd1, exp_active: 1'b1, exp_cnt: 4'd0};
    vecs[3] = '{pre: 3'b000, pre_len: 2'd0,
                bytes: {{4{8'hBC}}, 8'h0B, 8'hC0, 80'h0}, n_bytes: 5'd6,
                strobes: {8'h0B, 8'hC0, 16'h0}, n_strobes: 3'd2, exp_active: 1'b1, exp_cnt: 4'd0};
    vecs[4] = '{pre: 3'b000, pre_len: 2'd0, bytes: {{3{8'hBC}}, 104'h0}, n_bytes: 5'd3,
                strobes: 32'h0, n_strobes: 3'd0, exp_active: 1'b0, exp_cnt: 4'd3};
    vecs[5] = '{pre: 3'b000, pre_len: 2'd0, bytes: {16{8'hBC}}, n_bytes: 5'd16,
                strobes: 32'h0, n_strobes: 3'd0, exp_active: 1'b1, exp_cnt: 4'd15};

    do_reset(2);

    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      do_reset(2);
      for (int i = int'(v.pre_len) - 1; i >= 0; i--) send_bit(v.pre[i]);
      for (int i = 0; i < int'(v.n_bytes); i++) send_byte(v.bytes[127-8*i -: 8]);
      send_bits(8'h00, 4);
      check($sformatf("vec%0d strobe_count", k), strobe_q.size(), v.n_strobes);
      for (int i = 0; i < int'(v.n_strobes) && i < strobe_q.size(); i++)
        check($sformatf("vec%0d strobe%0d", k, i), strobe_q[i], v.strobes[31-8*i -: 8]);
      check($sformatf("vec%0d active", k), active, v.exp_active);
      check($sformatf("vec%0d com_count", k), com_count, v.exp_cnt);
    end

    // Lock at offset: active rises at the edge registering the 4th COM.
    do_reset(1);
    send_bits(8'h05, 3);
    repeat (4) send_byte(COM);
    send_bits(8'h00, 2);
    check("offset active_edge", first_active, 36);
    check("offset no_strobe", strobe_q.size(), 0);

    // Data after lock: latency and spacing of strobes.
    do_reset(1);
    repeat (4) send_byte(COM);
    send_byte(8'hA5); send_byte(8'h3C); send_byte(COM); send_byte(8'hFF);
    send_bits(8'h00, 3);
    check("data active_edge", first_active, 33);
    check("data strobe_count", strobe_t.size(), 3);
    if (strobe_t.size() == 3) begin
      check("A5 strobe_edge", strobe_t[0], 41);
      check("3C strobe_edge", strobe_t[1], 49);
      check("FF strobe_edge", strobe_t[2], 65);
      check("A5-3C spacing", strobe_t[1] - strobe_t[0], 8);
      check("3C-FF spacing", strobe_t[2] - strobe_t[1], 16);
    end

    // Broken confirm: com_count drops to 0 one edge after the bad byte.
    do_reset(1);
    send_byte(COM); send_byte(COM); send_byte(8'h12);
    send_bit(1'b1);
    check("broken com_count", com_count, 0);
    check("broken active", active, 0);
    send_bits(8'h3C, 7);
    repeat (3) send_byte(COM);
    send_byte(8'h77);
    send_bits(8'h00, 2);
    check("broken strobe_count", strobe_q.size(), 1);
    if (strobe_q.size() == 1) check("broken strobe", strobe_q[0], 8'h77);

    // Reset mid-lock at bit 4 of a byte, then relock.
    do_reset(1);
    repeat (4) send_byte(COM);
    send_bits(8'h0A, 4);
    check("prelock active", active, 1);
    do_reset(3);
    repeat (4) send_byte(COM);
    send_byte(8'h5A);
    send_bits(8'h00, 2);
    check("relock strobe_count", strobe_q.size(), 1);
    if (strobe_q.size() == 1) begin
      check("relock strobe", strobe_q[0], 8'h5A);
      check("relock strobe_edge", strobe_t[0], 41);
    end

    // Randomized streams: COM-heavy bytes, random bytes, slips, resets.
    for (int r = 0; r < 8; r++) begin
      do_reset(1 + r % 3);
      send_bits(8'($urandom), $urandom_range(0, 7));
      for (int j = 0; j < 250; j++) begin
        int sel;
        sel = $urandom_range(0, 19);
        if (sel < 10)       send_byte(COM);
        else if (sel < 17)  send_byte(8'($urandom));
        else if (sel < 19)  send_bits(8'($urandom), $urandom_range(1, 7));
        else if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 3));
        else                send_byte(8'h0B);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
